// File: rtl/next_piece_positions.sv
// Streams pseudo-legal target squares for KING/QUEEN/ROOK/BISHOP/KNIGHT, one candidate per clock.
// Optional debug ports (state/dir/dist mirrors) appear when NEXTPOS_DEBUG_EN is defined.
package next_piece_positions_pkg;
  typedef enum logic {WHITE = 1'b0, BLACK = 1'b1} color_t;
  typedef enum logic [2:0] {
    EMPTY = 3'd0, PAWN = 3'd1, KNIGHT = 3'd2, BISHOP = 3'd3,
    ROOK = 3'd4, QUEEN = 3'd5, KING = 3'd6
  } piece_t;
  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;
endpackage

module next_piece_positions
  import next_piece_positions_pkg::*;
#(
  parameter int MAX_RAY_LEN = 7,
  parameter int DIR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  fullpiece_t [63:0] board,
  input  logic              req,
  input  logic [5:0]        from_sq,
  input  piece_t            piece,
  input  color_t            color,
  output logic              ack,
  output logic              valid,
  output logic [5:0]        position,
  output logic              capture
`ifdef NEXTPOS_DEBUG_EN
  ,
  output logic [1:0]        out_state,
  output logic [DIR_W-1:0]  out_dir,
  output logic [2:0]        out_dist
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] MAX_DIST = 3'(MAX_RAY_LEN);

  state_t           state_q, state_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [2:0]       dist_q, dist_d;
  logic [5:0]       from_q, from_d;
  piece_t           piece_q, piece_d;
  color_t           color_q, color_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [5:0]       pos_q, pos_d;
  logic             cap_q, cap_d;

  logic signed [5:0] df, dr;
  logic signed [5:0] cf, cr, nf, nr;
  logic [5:0]        dist_ext, dist_nxt;
  logic              on_board, next_on_board;
  logic [5:0]        cand_sq;
  fullpiece_t        occupant;
  logic              applicable, slider, ray_end;

  // Per-direction (file,rank) step; knights use their own 8-entry table.
  always_comb begin
    df = 6'sd0;
    dr = 6'sd0;
    if (piece_q == KNIGHT) begin
      case (dir_q)
        3'd0: begin df =  6'sd1; dr =  6'sd2; end
        3'd1: begin df =  6'sd2; dr =  6'sd1; end
        3'd2: begin df =  6'sd2; dr = -6'sd1; end
        3'd3: begin df =  6'sd1; dr = -6'sd2; end
        3'd4: begin df = -6'sd1; dr = -6'sd2; end
        3'd5: begin df = -6'sd2; dr = -6'sd1; end
        3'd6: begin df = -6'sd2; dr =  6'sd1; end
        default: begin df = -6'sd1; dr = 6'sd2; end
      endcase
    end else begin
      case (dir_q)
        3'd0: begin df =  6'sd0; dr =  6'sd1; end
        3'd1: begin df =  6'sd1; dr =  6'sd1; end
        3'd2: begin df =  6'sd1; dr =  6'sd0; end
        3'd3: begin df =  6'sd1; dr = -6'sd1; end
        3'd4: begin df =  6'sd0; dr = -6'sd1; end
        3'd5: begin df = -6'sd1; dr = -6'sd1; end
        3'd6: begin df = -6'sd1; dr =  6'sd0; end
        default: begin df = -6'sd1; dr = 6'sd1; end
      endcase
    end
  end

  // Signed coordinates make off-board detection a simple high-bit test (no file wrap).
  assign dist_ext      = {3'd0, dist_q};
  assign dist_nxt      = dist_ext + 6'd1;
  assign cf            = $signed({3'd0, from_q[2:0]}) + $signed(dist_ext) * df;
  assign cr            = $signed({3'd0, from_q[5:3]}) + $signed(dist_ext) * dr;
  assign nf            = $signed({3'd0, from_q[2:0]}) + $signed(dist_nxt) * df;
  assign nr            = $signed({3'd0, from_q[5:3]}) + $signed(dist_nxt) * dr;
  assign on_board      = (cf[5:3] == 3'd0) && (cr[5:3] == 3'd0);
  assign next_on_board = (nf[5:3] == 3'd0) && (nr[5:3] == 3'd0);
  assign cand_sq       = {cr[2:0], cf[2:0]};
  assign occupant      = board[cand_sq];

  always_comb begin
    applicable = 1'b0;
    slider     = 1'b0;
    case (piece_q)
      KING, KNIGHT: applicable = 1'b1;
      QUEEN:  begin applicable = 1'b1;       slider = 1'b1; end
      ROOK:   begin applicable = ~dir_q[0];  slider = 1'b1; end
      BISHOP: begin applicable = dir_q[0];   slider = 1'b1; end
      default: applicable = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dist_d  = dist_q;
    from_d  = from_q;
    piece_d = piece_q;
    color_d = color_q;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    pos_d   = 6'd0;
    cap_d   = 1'b0;
    ray_end = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          from_d  = from_sq;
          piece_d = piece;
          color_d = color;
          dir_d   = '0;
          dist_d  = 3'd1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!req) begin
          state_d = S_IDLE;
          dir_d   = '0;
          dist_d  = 3'd1;
        end else begin
          if (applicable && on_board) begin
            pos_d = cand_sq;
            if (occupant.piece == EMPTY) begin
              valid_d = 1'b1;
              if (slider && (dist_q < MAX_DIST) && next_on_board)
                ray_end = 1'b0;
            end else if (occupant.color != color_q) begin
              valid_d = 1'b1;
              cap_d   = 1'b1;
            end
          end
          if (!ray_end) begin
            dist_d = dist_q + 3'd1;
          end else begin
            dist_d = 3'd1;
            if (dir_q == '1) begin
              state_d = S_DONE;
              ack_d   = 1'b1;
            end else begin
              dir_d = dir_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (req) ack_d = 1'b1;
        else     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      dist_q  <= 3'd1;
      from_q  <= 6'd0;
      piece_q <= EMPTY;
      color_q <= WHITE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      pos_q   <= 6'd0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dist_q  <= dist_d;
      from_q  <= from_d;
      piece_q <= piece_d;
      color_q <= color_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      pos_q   <= pos_d;
      cap_q   <= cap_d;
    end
  end

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign position = pos_q;
  assign capture  = cap_q;

`ifdef NEXTPOS_DEBUG_EN
  assign out_state = state_q;
  assign out_dir   = dir_q;
  assign out_dist  = dist_q;
`endif

endmodule

// File: tb/tb_next_piece_positions.sv
// Self-checking bench: directed scenarios plus random boards against a ray-walking reference model.
module tb_next_piece_positions;
  import next_piece_positions_pkg::*;

  localparam int MAXR = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  fullpiece_t [63:0] bd;
  logic              req;
  logic [5:0]        from_sq;
  piece_t            piece;
  color_t            color;
  logic              ack, valid, capture;
  logic [5:0]        position;
`ifdef NEXTPOS_DEBUG_EN
  logic [1:0]        out_state;
  logic [2:0]        out_dir;
  logic [2:0]        out_dist;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       v;
    logic       cap;
    logic [5:0] pos;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] obs_q[$];

  always #5 clk = ~clk;

  next_piece_positions #(.MAX_RAY_LEN(MAXR), .DIR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .board(bd), .req(req), .from_sq(from_sq),
    .piece(piece), .color(color), .ack(ack), .valid(valid),
    .position(position), .capture(capture)
`ifdef NEXTPOS_DEBUG_EN
    , .out_state(out_state), .out_dir(out_dir), .out_dist(out_dist)
`endif
  );

  // Reference: walk each ray square by square; each emitted entry is one expected clock cycle.
  function automatic void build_model(input int sq, input piece_t p, input color_t c);
    int kf[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int kr[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int sf[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int sr[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    exp_q.delete();
    for (int dir = 0; dir < 8; dir++) begin
      int  df, dr, reach, emitted;
      bit  ok;
      ok = (p == KING) || (p == QUEEN) || (p == KNIGHT) ||
           (p == ROOK && dir % 2 == 0) || (p == BISHOP && dir % 2 == 1);
      reach = (p == KING || p == KNIGHT) ? 1 : MAXR;
      df = (p == KNIGHT) ? kf[dir] : sf[dir];
      dr = (p == KNIGHT) ? kr[dir] : sr[dir];
      emitted = 0;
      if (ok) begin
        for (int d = 1; d <= reach; d++) begin
          int f, r, t;
          f = sq % 8 + d * df;
          r = sq / 8 + d * dr;
          if (f < 0 || f > 7 || r < 0 || r > 7) break;
          t = r * 8 + f;
          emitted++;
          if (bd[t].piece == EMPTY) begin
            exp_q.push_back('{v: 1'b1, cap: 1'b0, pos: 6'(t)});
          end else if (bd[t].color != c) begin
            exp_q.push_back('{v: 1'b1, cap: 1'b1, pos: 6'(t)});
            break;
          end else begin
            exp_q.push_back('{v: 1'b0, cap: 1'b0, pos: 6'(t)});
            break;
          end
        end
      end
      if (emitted == 0) exp_q.push_back('{v: 1'b0, cap: 1'b0, pos: 6'd0});
    end
  endfunction

  task automatic run_scan(input string name, input int sq, input piece_t p,
                          input color_t c, input int hold);
    logic [8:0] got, want;
    int n;
    build_model(sq, p, c);
    obs_q.delete();
    @(negedge clk);
    from_sq = 6'(sq); piece = p; color = c; req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({valid, ack} !== 2'b00)
      $display("FAIL %s start: got valid=%b ack=%b, expected 0 0", name, valid, ack);
    else passed++;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      got  = {valid, capture, ack, exp_q[i].v ? position : 6'd0};
      want = {exp_q[i].v, exp_q[i].cap, (i == n - 1), exp_q[i].v ? exp_q[i].pos : 6'd0};
      checks++;
      if (got !== want)
        $display("FAIL %s edge %0d: got v=%b cap=%b ack=%b pos=%0d, expected v=%b cap=%b ack=%b pos=%0d",
                 name, i + 1, got[8], got[7], got[6], got[5:0], want[8], want[7], want[6], want[5:0]);
      else passed++;
      if (valid === 1'b1) obs_q.push_back(position);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ack, valid} !== 2'b10)
        $display("FAIL %s hold %0d: got ack=%b valid=%b, expected 1 0", name, k, ack, valid);
      else passed++;
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ack, valid} !== 2'b00)
      $display("FAIL %s release: got ack=%b valid=%b, expected 0 0", name, ack, valid);
    else passed++;
  endtask

  task automatic check_obs(input string name, input int want[]);
    checks++;
    if (obs_q.size() != want.size())
      $display("FAIL %s count: got %0d valid cycles, expected %0d", name, obs_q.size(), want.size());
    else passed++;
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 6'(want[i]))
        $display("FAIL %s pos[%0d]: got %0d, expected %0d", name, i, obs_q[i], want[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; bd = '0; from_sq = 6'd0; piece = EMPTY; color = WHITE;
    repeat (2) @(posedge clk);
    req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ack, valid, capture, position} !== 9'd0)
      $display("FAIL reset: got ack=%b valid=%b cap=%b pos=%0d, expected all 0", ack, valid, capture, position);
    else passed++;
`ifdef NEXTPOS_DEBUG_EN
    checks++;
    if ({out_state, out_dir, out_dist} !== {2'd0, 3'd0, 3'd1})
      $display("FAIL reset_dbg: got state=%0d dir=%0d dist=%0d, expected 0 0 1", out_state, out_dir, out_dist);
    else passed++;
`endif
    @(negedge clk); req = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_king_center();
    bd = '0;
    run_scan("king_e4", 28, KING, WHITE, 0);
    check_obs("king_e4", '{36, 37, 29, 21, 20, 19, 27, 35});
  endtask

  task automatic test_king_corner();
    bd = '0;
    run_scan("king_a1", 0, KING, WHITE, 0);
    check_obs("king_a1", '{8, 9, 1});
  endtask

  task automatic test_rook_corner();
    bd = '0;
    run_scan("rook_a1", 0, ROOK, WHITE, 0);
    check_obs("rook_a1", '{8, 16, 24, 32, 40, 48, 56, 1, 2, 3, 4, 5, 6, 7});
  endtask

  task automatic test_rook_blocked();
    bd = '0;
    bd[27] = '{color: WHITE, piece: ROOK};
    bd[43] = '{color: WHITE, piece: PAWN};
    bd[29] = '{color: BLACK, piece: KNIGHT};
    run_scan("rook_d4", 27, ROOK, WHITE, 0);
    check_obs("rook_d4", '{35, 28, 29, 19, 11, 3, 26, 25, 24});
  endtask

  task automatic test_handshake();
    bd = '0;
    run_scan("hold_e4", 28, KING, WHITE, 5);
    run_scan("restart_h1", 7, KING, BLACK, 0);
    check_obs("restart_h1", '{15, 6, 14});
  endtask

  task automatic test_abort();
    bd = '0;
    @(negedge clk);
    from_sq = 6'd27; piece = KNIGHT; color = WHITE; req = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid, ack} !== 2'b00)
      $display("FAIL abort: got valid=%b ack=%b, expected 0 0", valid, ack);
    else passed++;
    run_scan("after_abort", 28, KING, WHITE, 0);
  endtask

  task automatic test_async_reset();
    bd = '0;
    @(negedge clk);
    from_sq = 6'd27; piece = QUEEN; color = WHITE; req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, valid, capture, position} !== 9'd0)
      $display("FAIL async_reset: got ack=%b valid=%b cap=%b pos=%0d, expected all 0", ack, valid, capture, position);
    else passed++;
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_scan("after_reset", 27, QUEEN, WHITE, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 99) < 35) begin
          bd[i].piece = piece_t'($urandom_range(1, 6));
          bd[i].color = color_t'($urandom_range(0, 1));
        end else begin
          bd[i] = '0;
        end
      end
      run_scan($sformatf("rand%0d", n), int'($urandom_range(0, 63)),
               piece_t'($urandom_range(0, 6)), color_t'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_king_center();
    test_king_corner();
    test_rook_corner();
    test_rook_blocked();
    test_handshake();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
